booth_mult_seq: RTL and testbench

Parametrised, iterative radix-2 Booth multiplier and successor to the team's 4-bit combinational Booth unit. It adds selectable signed/unsigned operation, one Booth step per clock, and valid/ready handshakes on both input and output. It sits between operand registers and the accumulate/result path of the arithmetic unit. It produces the exact full-width product for every operand pair, including the most-negative cases, with no special-case correction.

---
 rtl/booth_mult_seq.sv | 139 +++++++++++++
 tb/tb_booth_mult_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: iterative radix-2 Booth multiplier, one Booth step per clock.
//
// Operands are extended to WIDTH+1 bits (sign- or zero-extended by in_signed),
// so a single signed datapath covers both modes. The accumulator is WIDTH+2
// bits, which leaves room for the most-negative operand cases.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   in_a, in_b          multiplicand, multiplier
//   in_signed           1 = two's complement operands, 0 = unsigned
//   out_valid/out_ready product handshake
//   out_p               2*WIDTH-bit product, held until the next product
//   busy                high in RUN or DONE
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | WIDTH+1 Booth add/subtract + arithmetic shift steps
// DONE  | product presented on out_p, out_valid=1 until out_ready
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH:0]       r_a;
  logic [WIDTH+1:0]     r_upper;
  logic [WIDTH:0]       r_lower;
  logic                 r_e;
  logic [CW-1:0]        r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic [2*WIDTH-1:0]   r_p;

  logic [WIDTH:0]       w_a_in;
  logic [WIDTH:0]       w_b_in;
  logic [WIDTH+1:0]     w_a_ext;
  logic [WIDTH+1:0]     w_sum;
  logic [2*WIDTH+2:0]   w_shift;
  logic                 w_last;

  assign w_a_in  = {in_signed & in_a[WIDTH-1], in_a};
  assign w_b_in  = {in_signed & in_b[WIDTH-1], in_b};
  assign w_a_ext = {r_a[WIDTH], r_a};

  always_comb begin
    w_sum = r_upper;
    case ({r_lower[0], r_e})
      2'b10:   w_sum = r_upper - w_a_ext;
      2'b01:   w_sum = r_upper + w_a_ext;
      default: w_sum = r_upper;
    endcase
  end

  // Arithmetic right shift of {upper, lower}: replicate the accumulator sign.
  assign w_shift = {w_sum[WIDTH+1], w_sum, r_lower[WIDTH:1]};
  assign w_last  = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_upper     <= '0;
      r_lower     <= '0;
      r_e         <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_p         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= w_a_in;
            r_upper    <= '0;
            r_lower    <= w_b_in;
            r_e        <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_upper <= w_shift[2*WIDTH+2:WIDTH+1];
          r_lower <= w_shift[WIDTH:0];
          r_e     <= r_lower[0];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_p         <= w_shift[2*WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_p     = r_p;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Testbench for booth_mult_seq: a WIDTH=8 instance for directed, latency,
// backpressure and reset cases, and a WIDTH=4 instance swept exhaustively.
// Expected products are queued when operands are driven and compared when
// the product handshake is seen.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // WIDTH=8 instance
  logic        v8 = 0, ir8, s8 = 0, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] op8;
  logic [15:0] q8[$];

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .out_valid(ov8), .out_ready(or8), .out_p(op8), .busy(busy8)
  );

  // WIDTH=4 instance
  logic        v4 = 0, ir4, s4 = 0, ov4, or4 = 0, busy4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  op4;
  logic [7:0]  q4[$];

  booth_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .out_valid(ov4), .out_ready(or4), .out_p(op4), .busy(busy4)
  );

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[15:0];
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[7:0];
  endfunction

  // Scoreboard: compare on the cycle before each product handshake edge.
  always @(negedge clk) begin
    if (!rst && ov8 && or8) begin
      if (q8.size() == 0) chk("sb_spurious8", 1, 0);
      else chk("p8", op8, q8.pop_front());
    end
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) chk("sb_spurious4", 1, 0);
      else chk("p4", op4, q4.pop_front());
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int n = 0;
    while (!ir8 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!ir8) chk("timeout_ready8", 0, 1);
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1; lat++;
      if (ov8) return;
    end
    chk("timeout_valid8", 0, 1);
  endtask

  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
    int n = 0;
    while (!ir4 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!ir4) chk("timeout_ready4", 0, 1);
    a4 = a; b4 = b; s4 = s; v4 = 1'b1;
    q4.push_back(exp);
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  task automatic wait_valid4(output int lat);
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1; lat++;
      if (ov4) return;
    end
    chk("timeout_valid4", 0, 1);
  endtask

  task automatic op8_full(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int lat;
    start8(a, b, s, exp);
    wait_valid8(lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic rs;

    #12;
    chk("rst_in_ready8", ir8, 1);
    chk("rst_out_valid8", ov8, 0);
    chk("rst_busy8", busy8, 0);
    chk("rst_out_p8", op8, 0);
    chk("rst_in_ready4", ir4, 1);
    chk("rst_out_p4", op4, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Most-negative signed case plus latency and RUN-state flags.
    or8 = 1'b1;
    start8(8'h80, 8'h80, 1'b1, 16'h4000);
    chk("run_busy8", busy8, 1);
    chk("run_in_ready8", ir8, 0);
    chk("run_out_valid8", ov8, 0);
    wait_valid8(lat);
    chk("latency8", lat, 9);
    @(posedge clk); #1;
    chk("idle_after8", ir8, 1);

    op8_full(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    op8_full(8'hFF, 8'hFF, 1'b1, 16'h0001);
    op8_full(8'hFF, 8'h7F, 1'b1, 16'hFF81);
    op8_full(8'd200, 8'd3, 1'b0, 16'h0258);
    op8_full(8'h00, 8'h5A, 1'b0, 16'h0000);
    op8_full(8'h80, 8'h7F, 1'b1, 16'hC080);
    op8_full(8'h80, 8'h80, 1'b0, 16'h4000);

    // Back-to-back throughput with out_ready held high: WIDTH+3 cycles.
    start8(8'd7, 8'd9, 1'b0, 16'd63);
    wait_valid8(lat);
    a8 = 8'd5; b8 = 8'd6; s8 = 1'b0; v8 = 1'b1;
    q8.push_back(16'd30);
    @(posedge clk); #1;
    chk("b2b_ir8", ir8, 1);
    @(posedge clk); #1;
    v8 = 1'b0;
    chk("b2b_accept8", busy8, 1);
    wait_valid8(lat);
    chk("b2b_latency8", lat, 9);
    @(posedge clk); #1;

    // Backpressure in DONE, with stray in_valid that must be ignored.
    or8 = 1'b0;
    start8(8'h12, 8'h34, 1'b0, 16'h03A8);
    wait_valid8(lat);
    a8 = 8'h55; b8 = 8'h55; v8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid8", ov8, 1);
      chk("bp_hold8", op8, 16'h03A8);
      chk("bp_ready8", ir8, 0);
    end
    v8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_released8", ov8, 0);
    chk("bp_idle8", ir8, 1);
    chk("bp_keep8", op8, 16'h03A8);
    chk("bp_busy8", busy8, 0);

    // Asynchronous reset in the middle of RUN.
    start8(8'h7F, 8'h7F, 1'b1, 16'h3F01);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_busy8", busy8, 1);
    rst = 1'b1;
    #1;
    chk("arst_in_ready8", ir8, 1);
    chk("arst_out_valid8", ov8, 0);
    chk("arst_busy8", busy8, 0);
    chk("arst_out_p8", op8, 0);
    void'(q8.pop_back());
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    op8_full(8'h81, 8'h02, 1'b1, 16'hFF02);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      op8_full(ra, rb, rs, ref8(ra, rb, rs));
    end

    // WIDTH=4: directed corners then exhaustive sweep in both modes.
    or4 = 1'b1;
    start4(4'h8, 4'h8, 1'b1, 8'h40);
    wait_valid4(lat);
    chk("latency4", lat, 5);
    @(posedge clk); #1;
    start4(4'hF, 4'hF, 1'b0, 8'hE1);
    wait_valid4(lat);
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          start4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s)));
          wait_valid4(lat);
          @(posedge clk); #1;
        end
      end
    end

    repeat (2) @(posedge clk); #1;
    chk("sb_left8", q8.size(), 0);
    chk("sb_left4", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
